// File: rtl/box_draw_control_if.sv
// Control bundle between the box-drawing controller and the datapath/VGA adapter,
// plus the key input that sequences it.
interface box_draw_control_if #(
    parameter int CNT_W = 4
);
    logic             go;
    logic             ld_x;
    logic             ld_y;
    logic             ld_colour;
    logic             enable;
    logic             plot;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pix_cnt;

    modport master (
        input  go,
        output ld_x, ld_y, ld_colour, enable, plot, busy, done, pix_cnt
    );

    modport slave (
        output go,
        input  ld_x, ld_y, ld_colour, enable, plot, busy, done, pix_cnt
    );
endinterface

// File: rtl/box_draw_control.sv
// Moore control FSM: key-sequenced X load, Y+colour load, then a gap-free sweep
// of BOX_W*BOX_H plot cycles followed by a one-cycle done pulse.
module box_draw_control #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4,
    parameter int CNT_W = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    box_draw_control_if.master  bus,
    output logic [2:0]          state_o
);
    // go is a level from a debounced key: each press is a rise followed by a fall,
    // and every load state waits for the fall so one press loads exactly one value.
    typedef enum logic [2:0] {
        S_LOAD_X      = 3'd0,
        S_LOAD_X_WAIT = 3'd1,
        S_LOAD_Y      = 3'd2,
        S_LOAD_Y_WAIT = 3'd3,
        S_DRAW        = 3'd4,
        S_DONE        = 3'd5,
        S_REARM       = 3'd6
    } state_e;

    localparam int unsigned     NUM_PIX  = BOX_W * BOX_H;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIX - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_LOAD_X;
            pix_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        bus.ld_x      = 1'b0;
        bus.ld_y      = 1'b0;
        bus.ld_colour = 1'b0;
        bus.enable    = 1'b0;
        bus.plot      = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;

        unique case (state_q)
            S_LOAD_X: begin
                if (bus.go) state_d = S_LOAD_X_WAIT;
            end
            S_LOAD_X_WAIT: begin
                bus.ld_x = 1'b1;
                if (!bus.go) state_d = S_LOAD_Y;
            end
            S_LOAD_Y: begin
                if (bus.go) state_d = S_LOAD_Y_WAIT;
            end
            S_LOAD_Y_WAIT: begin
                bus.ld_y      = 1'b1;
                bus.ld_colour = 1'b1;
                if (!bus.go) begin
                    state_d   = S_DRAW;
                    pix_cnt_d = '0;
                end
            end
            S_DRAW: begin
                bus.enable = 1'b1;
                bus.plot   = 1'b1;
                bus.busy   = 1'b1;
                if (pix_cnt_q == LAST_PIX) begin
                    state_d   = S_DONE;
                    pix_cnt_d = '0;
                end else begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                bus.busy = 1'b1;
                state_d  = S_REARM;
            end
            S_REARM: begin
                // A key still held from the Y press must be released before the next X load.
                if (!bus.go) state_d = S_LOAD_X;
            end
            default: state_d = S_LOAD_X;
        endcase
    end

    assign bus.pix_cnt = pix_cnt_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_box_draw_control.sv
// Directed bench for box_draw_control: vector table for the full load/draw sequence,
// hand-written sequences for held key, async abort, go glitching and parameter corners.
module tb_box_draw_control;
  localparam logic [6:0] O_ZERO = 7'b0000000;
  localparam logic [6:0] O_LDX  = 7'b1000000;
  localparam logic [6:0] O_LDY  = 7'b0110000;
  localparam logic [6:0] O_DRAW = 7'b0001110;
  localparam logic [6:0] O_DONE = 7'b0000011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  box_draw_control_if #(.CNT_W(4)) bus_m ();
  box_draw_control_if #(.CNT_W(1)) bus_s ();
  box_draw_control_if #(.CNT_W(4)) bus_w ();
  logic [2:0] st_m, st_s, st_w;

  box_draw_control #(.BOX_W(4), .BOX_H(4), .CNT_W(4)) dut_m (
    .clock(clk), .reset_n(rst_n), .bus(bus_m), .state_o(st_m));
  box_draw_control #(.BOX_W(1), .BOX_H(1), .CNT_W(1)) dut_s (
    .clock(clk), .reset_n(rst_n), .bus(bus_s), .state_o(st_s));
  box_draw_control #(.BOX_W(8), .BOX_H(2), .CNT_W(4)) dut_w (
    .clock(clk), .reset_n(rst_n), .bus(bus_w), .state_o(st_w));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // shared key drives all three instances
  logic go = 1'b0;
  assign bus_m.go = go;
  assign bus_s.go = go;
  assign bus_w.go = go;

  function automatic logic [6:0] outs_m();
    return {bus_m.ld_x, bus_m.ld_y, bus_m.ld_colour, bus_m.enable, bus_m.plot, bus_m.busy, bus_m.done};
  endfunction
  function automatic logic [6:0] outs_w();
    return {bus_w.ld_x, bus_w.ld_y, bus_w.ld_colour, bus_w.enable, bus_w.plot, bus_w.busy, bus_w.done};
  endfunction
  function automatic logic [6:0] outs_s();
    return {bus_s.ld_x, bus_s.ld_y, bus_s.ld_colour, bus_s.enable, bus_s.plot, bus_s.busy, bus_s.done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply go, advance one clock, land 1ns after the edge
  task automatic step(input logic g);
    go = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    go = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_outs", outs_m(), O_ZERO);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       go;
    logic [6:0] exp_o;
    logic [3:0] exp_pix;
    logic [2:0] exp_st;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic g, input logic [6:0] o, input logic [3:0] p, input logic [2:0] s);
    vec_t v;
    v.go = g; v.exp_o = o; v.exp_pix = p; v.exp_st = s;
    vecs.push_back(v);
  endtask

  // scoreboard of expected pixel indices for the glitch sequence
  logic [3:0] exp_q[$];

  initial begin
    int s_plots, s_dones, w_plots;
    logic s_prev_plot;
    s_plots = 0; s_dones = 0; w_plots = 0; s_prev_plot = 1'b0;

    // full sequence table (4x4 and 8x2 both draw 16 pixels)
    add(1, O_LDX, 0, 1); add(1, O_LDX, 0, 1); add(1, O_LDX, 0, 1);
    add(0, O_ZERO, 0, 2); add(0, O_ZERO, 0, 2); add(0, O_ZERO, 0, 2);
    add(1, O_LDY, 0, 3); add(1, O_LDY, 0, 3);
    for (int i = 0; i < 16; i++) add(0, O_DRAW, 4'(i), 4);
    add(0, O_DONE, 0, 5);
    add(0, O_ZERO, 0, 6);
    add(0, O_ZERO, 0, 0);

    // 1. reset
    do_reset();
    chk("rst_state", 32'(st_m), 0);
    chk("rst_pix", 32'(bus_m.pix_cnt), 0);
    step(0);
    chk("post_rst_outs", outs_m(), O_ZERO);
    chk("post_rst_state", 32'(st_m), 0);

    // 2. full sequence, all instances observed together
    foreach (vecs[k]) begin
      step(vecs[k].go);
      chk($sformatf("seq%0d_outs", k), outs_m(), vecs[k].exp_o);
      chk($sformatf("seq%0d_pix", k), 32'(bus_m.pix_cnt), 32'(vecs[k].exp_pix));
      chk($sformatf("seq%0d_state", k), 32'(st_m), 32'(vecs[k].exp_st));
      chk($sformatf("seq%0d_w8x2_outs", k), outs_w(), vecs[k].exp_o);
      if (bus_w.plot) w_plots++;
      if (bus_s.plot) begin
        s_plots++;
        chk("s1x1_pix", 32'(bus_s.pix_cnt), 0);
      end
      if (bus_s.done) begin
        s_dones++;
        chk("s1x1_done_follows_plot", 32'(s_prev_plot), 1);
      end
      s_prev_plot = bus_s.plot;
    end
    chk("s1x1_plot_count", 32'(s_plots), 1);
    chk("s1x1_done_count", 32'(s_dones), 1);
    chk("w8x2_plot_count", 32'(w_plots), 16);
    chk("s1x1_final_outs", outs_s(), O_ZERO);

    // 3. held key: Y press held, then held across the draw and done
    step(1); chk("held_ldx", outs_m(), O_LDX);
    step(0); step(1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("held_y_wait", outs_m(), O_LDY);
    end
    step(0);
    chk("held_draw0", outs_m(), O_DRAW);
    for (int i = 1; i < 16; i++) begin
      step(1);
      chk("held_draw_pix", 32'(bus_m.pix_cnt), 32'(i));
      chk("held_draw_outs", outs_m(), O_DRAW);
    end
    step(1); chk("held_done", outs_m(), O_DONE);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("held_rearm_outs", outs_m(), O_ZERO);
      chk("held_rearm_state", 32'(st_m), 6);
    end
    step(0); chk("held_release_state", 32'(st_m), 0);
    step(1); chk("held_repress_ldx", outs_m(), O_LDX);
    step(0);

    // 4. asynchronous abort mid-draw
    do_reset();
    step(0);
    step(1); step(0); step(1); step(0);
    for (int i = 0; i < 7; i++) step(0);
    chk("abort_pix_before", 32'(bus_m.pix_cnt), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outs_async", outs_m(), O_ZERO);
    chk("abort_pix_async", 32'(bus_m.pix_cnt), 0);
    chk("abort_state_async", 32'(st_m), 0);
    step(0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk("abort_no_done", outs_m(), O_ZERO);
    end
    step(1); chk("abort_next_ldx", outs_m(), O_LDX);
    step(0);

    // 6. go toggling every cycle during the draw
    do_reset();
    step(0);
    step(1); step(0); step(1);
    for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
    step(0);
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() == 0) begin
        chk("glitch_queue_empty", 1, 0);
      end else begin
        chk("glitch_pix", 32'(bus_m.pix_cnt), 32'(exp_q.pop_front()));
      end
      chk("glitch_outs", outs_m(), O_DRAW);
      if (i < 15) step(logic'((i + 1) % 2));
    end
    step(0);
    chk("glitch_done", outs_m(), O_DONE);
    chk("glitch_queue_drained", 32'(exp_q.size()), 0);
    step(0);
    chk("glitch_rearm", outs_m(), O_ZERO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
